monitor_event_queue: RTL and testbench
======================================

# monitor_event_queue

Upstream stage of the RTLola monitor `topEntity`. It accepts raw input events (value of stream `x`), stamps each with a free-running cycle timestamp and buffers them in a FIFO. It feeds them to the monitor as single-cycle `new_input` pulses, but only while the monitor reports `pipeline_ready`. This absorbs bursts that arrive faster than the monitor pipeline can start new evaluations.

## Interface
Parameters:
- `DATA_W`, 64, width of the signed event value
- `TS_W`, 64, width of the timestamp counter
- `DEPTH`, 8, FIFO entries; must be a power of two, ≥ 2
- `DROP_W`, 16, width of the saturating drop counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  clock enable; low freezes all state
- `in_data`  in  DATA_W  signed event value
- `in_valid`  in  1  event present this cycle
- `in_ready`  out  1  queue not full
- `pipeline_ready`  in  1  monitor can accept a new event this cycle
- `input_x`  out  DATA_W  signed value presented to the monitor
- `input_ts`  out  TS_W  timestamp of the presented event
- `new_input`  out  1  one-cycle strobe, event on `input_x`/`input_ts` is new
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `dropped`  out  1  one-cycle pulse, event lost to overflow
- `drop_count`  out  DROP_W  saturating count of lost events

## Operation
- Timestamp counter `ts` starts at 0 and increments by 1 on every edge with `en`=1.
  - Wraps modulo 2^TS_W.
  - An event is stamped with `ts` as it stands in the accepting cycle, before the increment.
- Push: `en && in_valid && !full` writes {in_data, ts} at the write pointer.
- Overflow:
  - `en && in_valid && full` discards the event.
  - It pulses `dropped` and increments `drop_count`, saturating at all-ones.
  - A push is allowed when the queue is full and a pop happens in the same cycle. `in_ready` is `!full` only; it does not look ahead.
- Pop: `en && pipeline_ready && !empty` reads the head entry into the registered outputs `input_x`/`input_ts` and sets `new_input`=1 for the following cycle.
  - With no pop, `new_input`=0 and `input_x`/`input_ts` hold their last values.
- Simultaneous push and pop: both happen and `count` is unchanged.
  - On an empty queue the pushed event is not bypassed; it pops on a later cycle.
- `en`=0 freezes pointers, `ts`, outputs and counters.
  - `new_input` and `dropped` are forced to 0.
  - `in_valid` is ignored: the event is neither stored nor counted as dropped.
- Pointers are $clog2(DEPTH)+1 bits with wrap bit.
  - full = MSBs differ and LSBs equal.
  - empty = pointers equal.
- No state machine; the datapath is a FIFO plus registered output stage.

## Timing
- Reset values (asynchronous on `rst`=0, all outputs):
  - `input_x`=0, `input_ts`=0, `new_input`=0, `dropped`=0, `drop_count`=0, `count`=0, `in_ready`=1, `ts`=0.
- Reset mid-operation clears the FIFO contents logically (pointers reset); in-flight events are lost and not counted as dropped.
- Latency: an event accepted at edge k, into an empty queue with `pipeline_ready`=1 and `en`=1, gives `new_input`=1 in the cycle after edge k+1.
- Throughput: one event per cycle while `pipeline_ready` stays high.
- `pipeline_ready` is sampled in the same cycle as the pop decision; the monitor sees the strobe one cycle later.
- `in_ready` and `count` are registered state, valid from the cycle after each edge.
- `dropped` is high for exactly the cycle after the rejecting edge.

## Structure
- Shared package `monitor_pkg`:
  - defaults for `DATA_W` and `TS_W`
  - typedef `event_t` = packed {signed value, timestamp}
  - the `drop_count` saturation constant
- One sub-module, `event_fifo_mem`: DEPTH × `event_t` storage, synchronous write, combinational read at the read pointer.
  - Pointer, count and overflow logic stay in `monitor_event_queue`.

## Test plan
- Reset release with `en`=1 and no input → `new_input`=0 and `count`=0 for 20 cycles; `ts` advances 0,1,2,…
- Single event 5 at ts=3 with `pipeline_ready`=1 → exactly one `new_input` pulse with `input_x`=5 and `input_ts`=3, two edges after acceptance.
- Burst of 1..8 on consecutive cycles with `pipeline_ready`=0:
  - `count` reaches 8 and `in_ready`=0.
  - Event 9 → `dropped` pulse, `drop_count`=1.
  - Raise `pipeline_ready` → 1..8 emitted in order on 8 consecutive cycles.
- Full queue with push and pop in the same cycle → `count` stays 8, no drop, order preserved.
- `en`=0 for 4 cycles mid-burst → `ts`, `count` and outputs frozen, `new_input`=0, offered events neither stored nor dropped; resumes exactly on `en`=1.
- Assert `rst`=0 asynchronously between edges with `count`=3 → all outputs at reset values immediately; after release, no stale events emitted.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared types and defaults for the RTLola monitor input stage.
package monitor_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int TS_W_DEF   = 64;
  localparam int DROP_W_DEF = 16;

  // Drop counter stops here instead of wrapping back to zero.
  localparam logic [DROP_W_DEF-1:0] DROP_SAT = {DROP_W_DEF{1'b1}};

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] value;
    logic        [TS_W_DEF-1:0]   ts;
  } event_t;

endpackage

// File: rtl/event_fifo_mem.sv
// Event storage for the monitor input queue: synchronous write, combinational read.
module event_fifo_mem
  import monitor_pkg::*;
#(
  parameter type T     = event_t,
  parameter int  DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  T                         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output T                         rdata
);

  T mem_q [DEPTH];

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/monitor_event_queue.sv
// Timestamps raw input events, buffers them and releases one per cycle
// to the monitor while it reports pipeline_ready.
module monitor_event_queue
  import monitor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = 8,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       pipeline_ready,
  output logic signed [DATA_W-1:0]   input_x,
  output logic        [TS_W-1:0]     input_ts,
  output logic                       new_input,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dropped,
  output logic        [DROP_W-1:0]   drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  typedef struct packed {
    logic signed [DATA_W-1:0] value;
    logic        [TS_W-1:0]   ts;
  } entry_t;

  logic        [PW-1:0]     wptr_q, wptr_d;
  logic        [PW-1:0]     rptr_q, rptr_d;
  logic        [TS_W-1:0]   ts_q, ts_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic        [TS_W-1:0]   out_ts_q, out_ts_d;
  logic                     new_q, new_d;
  logic                     drop_q, drop_d;
  logic        [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic   full_s, empty_s, push_s, pop_s, drop_s;
  entry_t wr_entry_s, rd_entry_s;

  assign full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_s = (wptr_q == rptr_q);

  // A full queue still accepts when the head leaves in the same cycle.
  assign pop_s  = en && pipeline_ready && !empty_s;
  assign push_s = en && in_valid && (!full_s || pop_s);
  assign drop_s = en && in_valid && full_s && !pop_s;

  assign wr_entry_s = '{value: in_data, ts: ts_q};

  event_fifo_mem #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wptr_q[AW-1:0]),
    .wdata (wr_entry_s),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rd_entry_s)
  );

  // Next-state for pointers, timestamp, output stage and drop accounting.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ts_d       = ts_q;
    x_d        = x_q;
    out_ts_d   = out_ts_q;
    new_d      = 1'b0;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;

    if (en) begin
      ts_d = ts_q + TS_W'(1);
    end else begin
      ts_d = ts_q;
    end

    if (push_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d   = rptr_q + PW'(1);
      x_d      = rd_entry_s.value;
      out_ts_d = rd_entry_s.ts;
      new_d    = 1'b1;
    end else begin
      rptr_d   = rptr_q;
      x_d      = x_q;
      out_ts_d = out_ts_q;
      new_d    = 1'b0;
    end

    if (drop_s) begin
      drop_d = 1'b1;
      if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      drop_d     = 1'b0;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ts_q       <= '0;
      x_q        <= '0;
      out_ts_q   <= '0;
      new_q      <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ts_q       <= ts_d;
      x_q        <= x_d;
      out_ts_q   <= out_ts_d;
      new_q      <= new_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign input_x    = x_q;
  assign input_ts   = out_ts_q;
  assign new_input  = new_q;
  assign dropped    = drop_q;
  assign drop_count = drop_cnt_q;
  assign count      = wptr_q - rptr_q;
  assign in_ready   = !full_s;

endmodule

// File: tb/tb_monitor_event_queue.sv
// Randomized and directed bench for monitor_event_queue against a queue-based model.
module tb_monitor_event_queue;

  localparam int DEPTH = 8;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [63:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               pipeline_ready;
  logic signed [63:0] input_x;
  logic        [63:0] input_ts;
  logic               new_input;
  logic        [3:0]  count;
  logic               dropped;
  logic        [15:0] drop_count;

  monitor_event_queue #(
    .DATA_W (64),
    .TS_W   (64),
    .DEPTH  (DEPTH),
    .DROP_W (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pipeline_ready (pipeline_ready),
    .input_x        (input_x),
    .input_ts       (input_ts),
    .new_input      (new_input),
    .count          (count),
    .dropped        (dropped),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] v;
    logic [63:0] t;
  } ev_t;

  ev_t         mq[$];
  logic [63:0] m_tsc;
  logic [63:0] m_x;
  logic [63:0] m_ts;
  logic        m_new;
  logic        m_drop;
  logic [15:0] m_dcnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("new_input", {63'd0, new_input}, {63'd0, m_new});
    check_eq("dropped", {63'd0, dropped}, {63'd0, m_drop});
    check_eq("drop_count", {48'd0, drop_count}, {48'd0, m_dcnt});
    check_eq("count", {60'd0, count}, 64'(mq.size()));
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, (mq.size() != DEPTH)});
    check_eq("input_x", input_x, m_x);
    check_eq("input_ts", input_ts, m_ts);
  endtask

  // Drive one cycle, advance the model by the rules, compare after the edge.
  task automatic step(input logic v, input logic [63:0] d, input logic pr, input logic e);
    logic was_full;
    logic do_pop;
    ev_t  ev;
    en = e; in_valid = v; in_data = d; pipeline_ready = pr;
    if (e) begin
      was_full = (mq.size() == DEPTH);
      do_pop   = pr && (mq.size() != 0);
      m_new    = do_pop;
      m_drop   = 1'b0;
      if (do_pop) begin
        ev   = mq.pop_front();
        m_x  = ev.v;
        m_ts = ev.t;
      end
      if (v) begin
        if (!was_full || do_pop) begin
          mq.push_back('{v: d, t: m_tsc});
        end else begin
          m_drop = 1'b1;
          if (m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
        end
      end
      m_tsc = m_tsc + 64'd1;
    end else begin
      m_new  = 1'b0;
      m_drop = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    mq.delete();
    m_tsc = 64'd0; m_x = 64'd0; m_ts = 64'd0;
    m_new = 1'b0; m_drop = 1'b0; m_dcnt = 16'd0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = 64'sd0; pipeline_ready = 1'b0;
    model_reset();
    #2;
    check_all();
    #1 rst = 1'b1;

    // Idle after reset, then an event shows how far ts advanced.
    for (int i = 0; i < 20; i++) step(1'b0, 64'd0, 1'b1, 1'b1);
    step(1'b1, 64'd77, 1'b1, 1'b1);
    step(1'b0, 64'd0, 1'b1, 1'b1);
    check_eq("idle_ts", input_ts, 64'd20);
    check_eq("idle_x", input_x, 64'd77);

    // Single event at ts=3: strobe two edges after acceptance.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1, 1'b1);
    step(1'b1, 64'd5, 1'b1, 1'b1);
    check_eq("lat_early", {63'd0, new_input}, 64'd0);
    step(1'b0, 64'd0, 1'b1, 1'b1);
    check_eq("lat_new", {63'd0, new_input}, 64'd1);
    check_eq("lat_x", input_x, 64'd5);
    check_eq("lat_ts", input_ts, 64'd3);
    step(1'b0, 64'd0, 1'b1, 1'b1);
    check_eq("lat_once", {63'd0, new_input}, 64'd0);

    // Burst into a stalled monitor, overflow, then drain in order.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b0, 1'b1);
    check_eq("burst_count", {60'd0, count}, 64'd8);
    check_eq("burst_ready", {63'd0, in_ready}, 64'd0);
    step(1'b1, 64'd9, 1'b0, 1'b1);
    check_eq("ovf_dropped", {63'd0, dropped}, 64'd1);
    check_eq("ovf_dcnt", {48'd0, drop_count}, 64'd1);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    check_eq("ovf_pulse", {63'd0, dropped}, 64'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 64'd0, 1'b1, 1'b1);
      check_eq("drain_x", input_x, 64'(i));
    end
    check_eq("drain_empty", {60'd0, count}, 64'd0);

    // Full queue with push and pop together.
    for (int i = 10; i <= 17; i++) step(1'b1, 64'(i), 1'b0, 1'b1);
    step(1'b1, 64'd18, 1'b1, 1'b1);
    check_eq("pp_count", {60'd0, count}, 64'd8);
    check_eq("pp_nodrop", {63'd0, dropped}, 64'd0);
    check_eq("pp_x", input_x, 64'd10);
    for (int i = 0; i < 8; i++) step(1'b0, 64'd0, 1'b1, 1'b1);
    check_eq("pp_last", input_x, 64'd18);

    // Clock enable low freezes everything and ignores offered events.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 64'(100 + i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 64'd999, 1'b1, 1'b0);
      check_eq("frz_count", {60'd0, count}, 64'd3);
    end
    step(1'b1, 64'd200, 1'b1, 1'b1);
    check_eq("frz_resume", input_x, 64'd100);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 1'b1, 1'b1);
    check_eq("frz_stamp", input_ts, 64'd3);

    // Reset with three events queued; none may come out afterwards.
    for (int i = 0; i < 3; i++) step(1'b1, 64'(300 + i), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), {$urandom, $urandom},
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) < 17));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
